dl_meas_ctrl: RTL and testbench

Measurement controller that sits directly upstream and downstream of the delay line inside tt_um_ashleyjr_delay_line. It launches a rising edge into the line, captures the thermometer snapshot of the tap outputs one clock later, and converts the snapshot to a tap count. It repeats this for 2^LOG2_AVG samples, then reports the averaged, minimum and maximum counts, with a stuck-tap error flag, to the output mux.

---
 rtl/dl_meas_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dl_meas_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dl_meas_ctrl.sv
// dl_meas_ctrl
//   Delay-line measurement controller. Launches a rising edge into the
//   delay line, captures the thermometer tap snapshot at the closing edge of
//   the launch cycle, and converts it to a tap count with a popcount. This is
//   repeated for 2^LOG2_AVG samples. The block then reports the average,
//   minimum and maximum counts, plus a stuck-tap error flag.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   i_start     : request a measurement (sampled in IDLE only)
//   i_tap       : raw thermometer taps, bit 0 nearest the launch point
//   o_launch    : edge driven into the delay line (high for the LAUNCH cycle)
//   o_busy      : high in every state except IDLE
//   o_valid     : one-cycle pulse; result outputs are valid from this cycle
//   o_avg       : floor(sum of counts / SAMPLES)
//   o_min/o_max : extreme per-sample counts
//   o_err       : some tap was still high at the end of a drain period
module dl_meas_ctrl #(
  parameter int TAPS      = 32,
  parameter int LOG2_AVG  = 4,
  parameter int DRAIN_CYC = 4,
  localparam int CW       = $clog2(TAPS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [TAPS-1:0] i_tap,
  output logic            o_launch,
  output logic            o_busy,
  output logic            o_valid,
  output logic [CW-1:0]   o_avg,
  output logic [CW-1:0]   o_min,
  output logic [CW-1:0]   o_max,
  output logic            o_err
);

  localparam int SAMPLES = 1 << LOG2_AVG;
  localparam int AW      = CW + LOG2_AVG;          // holds SAMPLES*TAPS
  localparam int SW      = LOG2_AVG + 1;           // reaches SAMPLES
  localparam int DW      = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_SAMPLE, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TAPS-1:0] tap_q, tap_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   min_q, min_d;
  logic [CW-1:0]   max_q, max_d;
  logic            err_q, err_d;
  logic [SW-1:0]   smp_q, smp_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic [CW-1:0]   avg_q, avg_d;
  logic [CW-1:0]   omin_q, omin_d;
  logic [CW-1:0]   omax_q, omax_d;
  logic            oerr_q, oerr_d;
  logic [CW-1:0]   cnt;

  // Popcount rather than leading-ones so bubbles in the thermometer code
  // still contribute every high tap.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < TAPS; i++) cnt = cnt + CW'(tap_q[i]);
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    min_d   = min_q;
    max_d   = max_q;
    err_d   = err_q;
    smp_d   = smp_q;
    drn_d   = drn_q;
    avg_d   = avg_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    oerr_d  = oerr_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LAUNCH;
          acc_d   = '0;
          smp_d   = '0;
          min_d   = CW'(TAPS);
          max_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LAUNCH: begin
        tap_d   = i_tap;
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        acc_d   = acc_q + AW'(cnt);
        if (cnt < min_q) min_d = cnt;
        if (cnt > max_q) max_d = cnt;
        smp_d   = smp_q + 1'b1;
        drn_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DW'(DRAIN_CYC - 1)) begin
          err_d = err_q | (|i_tap);
          if (smp_q == SW'(SAMPLES)) begin
            // Results are loaded on the edge into DONE so they are already
            // valid while o_valid is high; err_d folds in this last check.
            state_d = S_DONE;
            avg_d   = acc_q[AW-1:LOG2_AVG];
            omin_d  = min_q;
            omax_d  = max_q;
            oerr_d  = err_d;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
      smp_q   <= '0;
      drn_q   <= '0;
      avg_q   <= '0;
      omin_q  <= '0;
      omax_q  <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      min_q   <= min_d;
      max_q   <= max_d;
      err_q   <= err_d;
      smp_q   <= smp_d;
      drn_q   <= drn_d;
      avg_q   <= avg_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      oerr_q  <= oerr_d;
    end
  end

  // All decoded straight from the state flop, so they are glitch-free
  // registered signals and drop together with reset.
  assign o_launch = (state_q == S_LAUNCH);
  assign o_busy   = (state_q != S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_avg    = avg_q;
  assign o_min    = omin_q;
  assign o_max    = omax_q;
  assign o_err    = oerr_q;

endmodule

// File: tb/tb_dl_meas_ctrl.sv
// Directed bench for dl_meas_ctrl (default parameters: 32 taps, 16 samples,
// 4 drain cycles). Taps are presented during each LAUNCH cycle and cleared
// afterwards (as a healthy line does), unless hold_taps keeps them high.
module tb_dl_meas_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_tap;
  logic        o_launch, o_busy, o_valid, o_err;
  logic [5:0]  o_avg, o_min, o_max;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] tap_seq [16];
  bit          hold_taps;
  bit          keep_start;
  int          valid_cyc, launches;
  bit          period_ok;

  dl_meas_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_tap(i_tap),
    .o_launch(o_launch), .o_busy(o_busy), .o_valid(o_valid),
    .o_avg(o_avg), .o_min(o_min), .o_max(o_max), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse i_start, feed tap_seq[k] during the k-th LAUNCH cycle, and stop at
  // o_valid (cycle 1 = first cycle after the edge that sampled i_start).
  task automatic measure();
    int last_launch;
    valid_cyc   = 0;
    launches    = 0;
    period_ok   = 1'b1;
    last_launch = 0;
    i_start = 1'b1;
    tick();
    if (!keep_start) i_start = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (o_valid) begin
        valid_cyc = cyc;
        break;
      end
      if (o_launch) begin
        if (launches > 0 && cyc - last_launch != 6) period_ok = 1'b0;
        last_launch = cyc;
        i_tap = tap_seq[launches % 16];
        launches++;
      end else if (!hold_taps) begin
        i_tap = 32'h0;
      end
      tick();
    end
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 16; k++) tap_seq[k] = (k % 2 == 0) ? a : b;
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_tap = 32'h0;
    hold_taps = 1'b0; keep_start = 1'b0;
    tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_launch", o_launch, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_avg", o_avg, 0);
    chk("rst_min", o_min, 0);
    chk("rst_max", o_max, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b0;
    tick();

    // 1: constant count 10
    fill(32'h0000_03FF, 32'h0000_03FF);
    measure();
    chk("t1_valid_cyc", valid_cyc, 97);
    chk("t1_launches", launches, 16);
    chk("t1_period", period_ok, 1);
    chk("t1_busy_in_done", o_busy, 1);
    chk("t1_avg", o_avg, 10);
    chk("t1_min", o_min, 10);
    chk("t1_max", o_max, 10);
    chk("t1_err", o_err, 0);
    tick();
    chk("t1_valid_pulse", o_valid, 0);
    chk("t1_busy_idle", o_busy, 0);
    chk("t1_hold_avg", o_avg, 10);
    tick();

    // 2: alternating 4 / 12
    fill(32'h0000_000F, 32'h0000_0FFF);
    measure();
    chk("t2_valid_cyc", valid_cyc, 97);
    chk("t2_avg", o_avg, 8);
    chk("t2_min", o_min, 4);
    chk("t2_max", o_max, 12);
    chk("t2_err", o_err, 0);
    tick(); tick();

    // 3: all taps stuck high
    fill(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    hold_taps = 1'b1;
    i_tap = 32'hFFFF_FFFF;
    measure();
    hold_taps = 1'b0;
    i_tap = 32'h0;
    chk("t3_avg", o_avg, 32);
    chk("t3_min", o_min, 32);
    chk("t3_max", o_max, 32);
    chk("t3_err", o_err, 1);
    tick(); tick();

    // 4: fifteen zero samples, then one of 15 -> truncated average
    fill(32'h0, 32'h0);
    tap_seq[15] = 32'h0000_7FFF;
    measure();
    chk("t4_avg", o_avg, 0);
    chk("t4_min", o_min, 0);
    chk("t4_max", o_max, 15);
    chk("t4_err", o_err, 0);
    tick(); tick();

    // 6: bubbled thermometer code, popcount 7
    fill(32'h0000_00F7, 32'h0000_00F7);
    measure();
    chk("t6_avg", o_avg, 7);
    chk("t6_min", o_min, 7);
    chk("t6_max", o_max, 7);
    chk("t6_err", o_err, 0);
    tick(); tick();

    // 5: start spam while busy, then reset at cycle 40
    begin
      bit saw_valid;
      saw_valid = 1'b0;
      i_start = 1'b1;
      tick();
      for (int cyc = 1; cyc < 40; cyc++) begin
        i_start = cyc[0];
        if (o_valid) saw_valid = 1'b1;
        tick();
      end
      chk("t5_no_valid", saw_valid, 0);
      chk("t5_busy_pre", o_busy, 1);
      rst = 1'b1;
      i_start = 1'b0;
      #1;
      chk("t5_busy", o_busy, 0);
      chk("t5_launch", o_launch, 0);
      chk("t5_valid", o_valid, 0);
      chk("t5_avg", o_avg, 0);
      chk("t5_min", o_min, 0);
      chk("t5_max", o_max, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("t5_idle", o_busy, 0);
      fill(32'h0000_03FF, 32'h0000_03FF);
      measure();
      chk("t5_valid_cyc", valid_cyc, 97);
      chk("t5_launches", launches, 16);
      chk("t5_avg", o_avg, 10);
    end
    tick(); tick();

    // start held through DONE: one IDLE cycle, then LAUNCH
    keep_start = 1'b1;
    measure();
    chk("hold_valid_cyc", valid_cyc, 97);
    tick();
    chk("hold_idle", o_busy, 0);
    tick();
    chk("hold_relaunch", o_launch, 1);
    keep_start = 1'b0;
    i_start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
